// File: rtl/elevator_ctrl.sv
// Four-floor elevator motion controller: fetches one hall call per trip, travels
// floor by floor, opens the door. Optional door-hold input under ELEV_DOOR_HOLD_EN.
module elevator_ctrl #(
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_code,
  input  logic       q_empty,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic       done,
  output logic [1:0] floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic [1:0] dir_lamp,
  output logic       served
);

  typedef enum logic [2:0] {IDLE, FETCH, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  localparam logic [7:0] MOVE_RELOAD = 8'(MOVE_CYCLES - 1);
  localparam logic [7:0] DOOR_RELOAD = 8'(DOOR_CYCLES - 1);

  state_t     state, state_d;
  logic [7:0] timer, timer_d;
  logic [1:0] target, target_d;
  logic [1:0] floor_d, dir_d;
  logic       code_ok;
  logic [1:0] code_tgt, code_dir;
  logic       hold;

  // Buffer-empty is informational only; the fetch loop polls regardless.
  logic unused_q_empty;
  assign unused_q_empty = q_empty;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    code_ok  = 1'b1;
    code_tgt = 2'd0;
    code_dir = 2'b00;
    case (req_code)
      3'b001:  begin code_tgt = 2'd0; code_dir = 2'b10; end
      3'b010:  begin code_tgt = 2'd1; code_dir = 2'b10; end
      3'b011:  begin code_tgt = 2'd2; code_dir = 2'b10; end
      3'b110:  begin code_tgt = 2'd1; code_dir = 2'b01; end
      3'b111:  begin code_tgt = 2'd2; code_dir = 2'b01; end
      3'b100:  begin code_tgt = 2'd3; code_dir = 2'b01; end
      default: code_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state;
    timer_d  = timer;
    target_d = target;
    floor_d  = floor;
    dir_d    = dir_lamp;
    case (state)
      // done is low only in the first IDLE cycle after reset; hold there once
      // so every fetch is preceded by a real strobe.
      IDLE: if (done) state_d = FETCH;
      FETCH: begin
        if (!code_ok) begin
          state_d = IDLE;
        end else begin
          target_d = code_tgt;
          dir_d    = code_dir;
          if (code_tgt == floor) begin
            state_d = DOOR;
            timer_d = DOOR_RELOAD;
          end else begin
            state_d = (code_tgt > floor) ? MOVE_UP : MOVE_DOWN;
            timer_d = MOVE_RELOAD;
          end
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer != 8'd0) begin
          timer_d = timer - 8'd1;
        end else if ((state == MOVE_UP && floor == 2'd3) ||
                     (state == MOVE_DOWN && floor == 2'd0)) begin
          state_d = DOOR;
          timer_d = DOOR_RELOAD;
        end else begin
          floor_d = (state == MOVE_UP) ? floor + 2'd1 : floor - 2'd1;
          if (floor_d == target) begin
            state_d = DOOR;
            timer_d = DOOR_RELOAD;
          end else begin
            timer_d = MOVE_RELOAD;
          end
        end
      end
      DOOR: begin
        if (hold) begin
          timer_d = DOOR_RELOAD;
        end else if (timer == 8'd0) begin
          state_d = IDLE;
          dir_d   = 2'b00;
        end else begin
          timer_d = timer - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= 8'd0;
      target      <= 2'd0;
      floor       <= 2'd0;
      dir_lamp    <= 2'b00;
      done        <= 1'b0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
      served      <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      target      <= target_d;
      floor       <= floor_d;
      dir_lamp    <= dir_d;
      done        <= (state_d == IDLE);
      moving_up   <= (state_d == MOVE_UP);
      moving_down <= (state_d == MOVE_DOWN);
      door_open   <= (state_d == DOOR);
      served      <= (state_d == DOOR) && (state != DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: per-trip expected timelines derived
// arithmetically from start floor, target and latency rules.
module tb_elevator_ctrl;
  localparam int MC = 8;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_code = 3'b000;
  logic       q_empty = 1'b1;
`ifdef ELEV_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  logic       done, moving_up, moving_down, door_open, served;
  logic [1:0] floor, dir_lamp;

  int errors = 0;
  int checks = 0;
  int mfloor = 0;

  elevator_ctrl #(.MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .req_code(req_code), .q_empty(q_empty),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .done(done), .floor(floor), .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .dir_lamp(dir_lamp), .served(served)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {done, moving_up, moving_down, door_open, served, dir_lamp, floor};
  endfunction

  // Hall-call table: target floor index and lamp, or invalid.
  task automatic decode(input logic [2:0] code, output bit ok, output int t, output logic [1:0] dv);
    ok = 1; t = 0; dv = 2'b00;
    case (code)
      3'b001: begin t = 0; dv = 2'b10; end
      3'b010: begin t = 1; dv = 2'b10; end
      3'b011: begin t = 2; dv = 2'b10; end
      3'b110: begin t = 1; dv = 2'b01; end
      3'b111: begin t = 2; dv = 2'b01; end
      3'b100: begin t = 3; dv = 2'b01; end
      default: ok = 0;
    endcase
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done never seen, got %b required 1", name, done);
    end
  endtask

  // Called in the done cycle; runs one fetch through to the next done cycle.
  task automatic do_call(input logic [2:0] code, input string name);
    bit ok; int t, d, f, lat, fl; logic [1:0] dv; logic [8:0] exp_v;
    decode(code, ok, t, dv);
    f = mfloor;
    req_code = code;
    if (!ok) begin
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk);
        exp_v = {(k == 2), 6'b0, 2'(f)};
        checks++;
        if (obs() !== exp_v) begin
          errors++;
          $display("FAIL %s k=%0d: got %b required %b", name, k, obs(), exp_v);
        end
      end
    end else begin
      d = (t > f) ? t - f : f - t;
      lat = 2 + d * MC;
      for (int k = 1; k <= lat + DC; k++) begin
        @(negedge clk);
        if (k == 2) req_code = 3'($urandom_range(0, 7));
        if (k == 1)
          exp_v = {7'b0, 2'(f)};
        else if (k < lat) begin
          fl = (t > f) ? f + (k - 2) / MC : f - (k - 2) / MC;
          exp_v = {1'b0, (t > f), (t < f), 2'b00, dv, 2'(fl)};
        end else if (k < lat + DC)
          exp_v = {3'b000, 1'b1, (k == lat), dv, 2'(t)};
        else
          exp_v = {1'b1, 6'b0, 2'(t)};
        checks++;
        if (obs() !== exp_v) begin
          errors++;
          $display("FAIL %s k=%0d code=%b: got %b required %b", name, k, code, obs(), exp_v);
        end
      end
      mfloor = t;
    end
    req_code = 3'b000;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs() !== 9'b0) begin
      errors++;
      $display("FAIL reset_vals: got %b required %b", obs(), 9'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mfloor = 0;
    wait_done("reset_first_done");
  endtask

  task automatic test_idle_poll();
    logic [8:0] exp_v;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      q_empty = 1'($urandom);
      exp_v = {(k % 2 == 0), 8'b0};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL idle_poll k=%0d: got %b required %b", k, obs(), exp_v);
      end
    end
  endtask

  task automatic test_directed();
    do_call(3'b100, "up_0_to_3");
    do_call(3'b001, "down_3_to_0");
    do_call(3'b010, "up_0_to_1");
    do_call(3'b110, "same_floor_2D");
    do_call(3'b101, "invalid_101");
    do_call(3'b000, "invalid_000");
    do_call(3'b111, "up_1_to_2_D");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) do_call(3'($urandom_range(0, 7)), "random_call");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    if (mfloor != 0) do_call(3'b001, "home_to_0");
    req_code = 3'b100;
    while (floor !== 2'd2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    req_code = 3'b000;
    checks++;
    if (floor !== 2'd2 || moving_up !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: floor=%0d up=%b required floor=2 up=1", floor, moving_up);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got %b required %b", obs(), 9'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mfloor = 0;
    wait_done("reset_mid_done");
    checks++;
    if (floor !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_floor: got %0d required 0", floor);
    end
  endtask

`ifdef ELEV_DOOR_HOLD_EN
  task automatic test_door_hold();
    logic [2:0] codes [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    int cnt = 0;
    req_code = codes[mfloor];
    @(negedge clk);
    @(negedge clk);
    door_hold = 1'b1;
    for (int i = 0; i < 40 && door_open === 1'b1; i++) begin
      cnt++;
      if (cnt == 11) door_hold = 1'b0;
      @(negedge clk);
    end
    door_hold = 1'b0;
    req_code = 3'b000;
    checks++;
    if (cnt != 10 + DC) begin
      errors++;
      $display("FAIL door_hold_len: got %0d required %0d", cnt, 10 + DC);
    end
    wait_done("door_hold_done");
  endtask
`endif

  initial begin
    test_reset();
    test_idle_poll();
    wait_done("poll_resync");
    test_directed();
    test_random();
`ifdef ELEV_DOOR_HOLD_EN
    test_door_hold();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end
endmodule
